alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Frame-level controller sitting between the UART RX/TX FIFOs and the combinational ALU. It pops a three-byte command frame (operand A, operand B, opcode) from the RX FIFO and drives the ALU operand/opcode buses. After a configurable settle delay it latches the ALU result and flags and pushes a two-byte response (result, then flags) into the TX FIFO. Incomplete frames are discarded after an RX inactivity timeout and reported by an error pulse.

## Interface
Parameters:
- BUS_SIZE, 8, data width of FIFO bytes, operands and result
- OP_SIZE, 6, opcode width; the low OP_SIZE bits of the third byte
- ALU_LATENCY, 1, EXEC cycles before result/flags are latched (≥1)
- TIMEOUT_CYCLES, 1000, consecutive empty-RX cycles tolerated mid-frame (≥2)

Ports:
- clk  in  1  single clock; all logic rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  BUS_SIZE  RX FIFO head byte, first-word-fall-through, valid while i_rx_empty=0
- i_rx_empty  in  1  RX FIFO empty
- o_rd  out  1  RX pop strobe
- o_op_a  out  BUS_SIZE  ALU operand A (registered)
- o_op_b  out  BUS_SIZE  ALU operand B (registered)
- o_op_code  out  OP_SIZE  ALU opcode (registered)
- i_alu_result  in  BUS_SIZE  ALU result
- i_alu_flags  in  5  ALU flags
- i_tx_full  in  1  TX FIFO full
- o_wr  out  1  TX push strobe
- o_tx_data  out  BUS_SIZE  byte presented to TX FIFO
- o_busy  out  1  frame in progress (state ≠ GET_A)
- o_frame_err  out  1  one-cycle pulse on timeout discard

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND_RES, SEND_FLG.
- GET_A/GET_B/GET_OP: o_rd = ~i_rx_empty (combinational). On an edge with o_rd=1, i_rx_data is captured into o_op_a / o_op_b / o_op_code (low OP_SIZE bits, upper bits ignored) and the state advances.
- EXEC: counts ALU_LATENCY cycles; on the last, i_alu_result and {3'b000, i_alu_flags} are latched into res_q/flg_q and the state moves to SEND_RES.
- SEND_RES: o_tx_data = res_q, o_wr = ~i_tx_full; advance on the push edge. SEND_FLG: same with flg_q, then return to GET_A.
- o_rd is 0 outside GET_*; o_wr is 0 outside SEND_*; o_rd and o_wr are never high together.
- o_tx_data = 0 outside SEND_*.
- Operand/opcode registers hold until overwritten by the next frame's capture.
- Timeout: in GET_B/GET_OP, the counter increments each cycle i_rx_empty=1 and clears on every pop and on entry to GET_A.
  - On the TIMEOUT_CYCLES-th consecutive empty cycle: next state GET_A, counter cleared, o_frame_err registered high for exactly one cycle.
  - Operands already captured are left as-is; no TX write.
- No timeout in GET_A, EXEC or SEND_* (TX backpressure may stall indefinitely).

## Timing
- Reset (sync, priority over everything): state GET_A; o_op_a=o_op_b=o_op_code=0; res_q=flg_q=0; counters 0; o_frame_err=0.
  - Combinational outputs follow: o_rd = ~i_rx_empty, o_wr=0, o_busy=0.
  - A reset mid-frame discards the partial frame with no TX write and no error pulse.
- Minimum frame latency with a non-empty RX and non-full TX: pops on edges N, N+1, N+2; EXEC spans ALU_LATENCY cycles; result pushed on edge N+3+ALU_LATENCY, flags on the following edge.
- Back-to-back frames: GET_A is entered the cycle after the flags push, so the next pop can occur on that edge+1.
- Data arriving in the same cycle as the terminal timeout count wins: the pop occurs, the state advances, and no error is raised.
- i_tx_full rising in SEND_RES holds state and res_q; o_wr drops the same cycle.

## Test plan
- Bytes 0x05, 0x03, 0x20 pre-loaded, TX empty → o_op_a=0x05, o_op_b=0x03, o_op_code=0x20; TX receives res then {3'b0,flags} at the documented edges; o_busy returns to 0.
- Third byte 0xE1 → o_op_code=0x21 (upper bits dropped).
- 0x0A, 0x0B, then RX empty for TIMEOUT_CYCLES cycles → one o_frame_err pulse, no o_wr, state GET_A; the next 3 bytes form a fresh frame.
- Same as above but the byte arrives on the terminal empty cycle → no error; frame completes normally.
- i_tx_full held high for 50 cycles in SEND_RES → o_wr=0, o_tx_data stable at res_q; after release, exactly two pushes occur, in order.
- i_reset pulsed while in GET_OP and while in SEND_FLG → all registers 0; no further o_wr; the next frame processes correctly.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Frame controller between the UART RX/TX FIFOs and a combinational ALU. It pops a three-byte
// command frame (operand A, operand B, opcode) and drives the ALU buses from registers. After
// ALU_LATENCY cycles it latches the result and flags, then pushes result followed by flags into
// the TX FIFO. A frame left incomplete for TIMEOUT_CYCLES empty-RX cycles is dropped and
// reported with a one-cycle o_frame_err pulse.
//
// Ports:
//   clk, i_reset               clock, synchronous active-high reset
//   i_rx_data, i_rx_empty      FWFT RX FIFO head byte and empty flag
//   o_rd                       RX pop strobe
//   o_op_a, o_op_b, o_op_code  registered ALU operands / opcode
//   i_alu_result, i_alu_flags  ALU outputs
//   i_tx_full, o_wr, o_tx_data TX FIFO full flag, push strobe and byte
//   o_busy                     frame in progress
//   o_frame_err                one-cycle pulse on timeout discard
module alu_cmd_sequencer #(
  parameter int unsigned BUS_SIZE       = 8,
  parameter int unsigned OP_SIZE        = 6,
  parameter int unsigned ALU_LATENCY    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [BUS_SIZE-1:0] i_rx_data,
  input  logic                i_rx_empty,
  output logic                o_rd,
  output logic [BUS_SIZE-1:0] o_op_a,
  output logic [BUS_SIZE-1:0] o_op_b,
  output logic [OP_SIZE-1:0]  o_op_code,
  input  logic [BUS_SIZE-1:0] i_alu_result,
  input  logic [4:0]          i_alu_flags,
  input  logic                i_tx_full,
  output logic                o_wr,
  output logic [BUS_SIZE-1:0] o_tx_data,
  output logic                o_busy,
  output logic                o_frame_err
);

  localparam logic [2:0] StGetA    = 3'd0;
  localparam logic [2:0] StGetB    = 3'd1;
  localparam logic [2:0] StGetOp   = 3'd2;
  localparam logic [2:0] StExec    = 3'd3;
  localparam logic [2:0] StSendRes = 3'd4;
  localparam logic [2:0] StSendFlg = 3'd5;

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ExW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [ExW-1:0] ExLast = ExW'(ALU_LATENCY - 1);

  logic [2:0]          state_q, state_d;
  logic [BUS_SIZE-1:0] op_a_q, op_a_d;
  logic [BUS_SIZE-1:0] op_b_q, op_b_d;
  logic [OP_SIZE-1:0]  op_code_q, op_code_d;
  logic [BUS_SIZE-1:0] res_q, res_d;
  logic [BUS_SIZE-1:0] flg_q, flg_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic [ExW-1:0]      ex_cnt_q, ex_cnt_d;
  logic                err_q, err_d;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    res_d     = res_q;
    flg_d     = flg_q;
    // Both counters idle at zero unless their state explicitly advances them.
    to_cnt_d  = '0;
    ex_cnt_d  = '0;
    err_d     = 1'b0;
    o_rd      = 1'b0;
    o_wr      = 1'b0;
    o_tx_data = '0;

    case (state_q)
      StGetA: begin
        o_rd = ~i_rx_empty;
        if (!i_rx_empty) begin
          op_a_d  = i_rx_data;
          state_d = StGetB;
        end
      end
      StGetB, StGetOp: begin
        o_rd = ~i_rx_empty;
        // A byte present on the terminal count still wins over the timeout.
        if (!i_rx_empty) begin
          if (state_q == StGetB) begin
            op_b_d  = i_rx_data;
            state_d = StGetOp;
          end else begin
            op_code_d = i_rx_data[OP_SIZE-1:0];
            state_d   = StExec;
          end
        end else if (to_cnt_q == ToLast) begin
          state_d = StGetA;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StExec: begin
        if (ex_cnt_q == ExLast) begin
          res_d   = i_alu_result;
          flg_d   = BUS_SIZE'(i_alu_flags);
          state_d = StSendRes;
        end else begin
          ex_cnt_d = ex_cnt_q + 1'b1;
        end
      end
      StSendRes: begin
        o_tx_data = res_q;
        o_wr      = ~i_tx_full;
        if (!i_tx_full) state_d = StSendFlg;
      end
      StSendFlg: begin
        o_tx_data = flg_q;
        o_wr      = ~i_tx_full;
        if (!i_tx_full) state_d = StGetA;
      end
      default: state_d = StGetA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= StGetA;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      to_cnt_q  <= '0;
      ex_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      res_q     <= res_d;
      flg_q     <= flg_d;
      to_cnt_q  <= to_cnt_d;
      ex_cnt_q  <= ex_cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_op_a      = op_a_q;
  assign o_op_b      = op_b_q;
  assign o_op_code   = op_code_q;
  assign o_busy      = (state_q != StGetA);
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: RX/TX FIFOs and the ALU are modelled in the bench; frames are
// applied from a vector table, hand-written corner sequences and a randomized run whose expected
// TX byte stream is derived frame by frame.
module tb_alu_cmd_sequencer;
  localparam int unsigned Lat = 2;
  localparam int unsigned To  = 16;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_empty = 1'b1;
  logic       o_rd;
  logic [7:0] o_op_a, o_op_b;
  logic [5:0] o_op_code;
  logic [7:0] i_alu_result;
  logic [4:0] i_alu_flags;
  logic       full_req = 1'b0;
  logic       rand_full = 1'b0;
  logic       rand_full_val = 1'b0;
  wire        i_tx_full = rand_full ? rand_full_val : full_req;
  logic       o_wr;
  logic [7:0] o_tx_data;
  logic       o_busy, o_frame_err;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .BUS_SIZE      (8),
    .OP_SIZE       (6),
    .ALU_LATENCY   (Lat),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_empty  (i_rx_empty),
    .o_rd        (o_rd),
    .o_op_a      (o_op_a),
    .o_op_b      (o_op_b),
    .o_op_code   (o_op_code),
    .i_alu_result(i_alu_result),
    .i_alu_flags (i_alu_flags),
    .i_tx_full   (i_tx_full),
    .o_wr        (o_wr),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  // Reference ALU
  function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [7:0] s;
    s = a + b;
    return s ^ {2'b00, op};
  endfunction

  function automatic logic [4:0] alu_flg(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    return a[7:3] ^ b[4:0] ^ op[4:0];
  endfunction

  always_comb begin
    i_alu_result = alu_res(o_op_a, o_op_b, o_op_code);
    i_alu_flags  = alu_flg(o_op_a, o_op_b, o_op_code);
  end

  // FIFO models and event logs
  logic [7:0] rx_q[$];
  int         pop_pend = 0;
  int         cyc = 0;
  int         pop_edges[$];
  logic [7:0] tx_data_log[$];
  int         tx_edge_log[$];
  int         err_cnt = 0;
  int         err_edge = -1;
  int         overlap = 0;

  always @(posedge clk) begin
    if (o_rd && !i_reset) begin
      pop_pend++;
      pop_edges.push_back(cyc);
    end
    if (o_wr) begin
      tx_data_log.push_back(o_tx_data);
      tx_edge_log.push_back(cyc);
    end
    if (o_frame_err) begin
      err_cnt++;
      err_edge = cyc;
    end
    if (o_rd && o_wr) overlap++;
    cyc++;
  end

  always @(negedge clk) begin
    while (pop_pend > 0 && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      pop_pend--;
    end
    pop_pend      = 0;
    i_rx_empty    = (rx_q.size() == 0);
    i_rx_data     = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    rand_full_val = ($urandom_range(0, 3) == 0);
  end

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    pop_edges.delete();
    tx_data_log.delete();
    tx_edge_log.delete();
  endtask

  task automatic wait_pops(input string name, input int n);
    int k = 0;
    while (pop_edges.size() < n && k < 2000) begin
      tick(1);
      k++;
    end
    check({name, " pop count"}, pop_edges.size(), n);
  endtask

  task automatic wait_pushes(input string name, input int n, input int budget);
    int k = 0;
    while (tx_data_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({name, " push count"}, tx_data_log.size(), n);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(c);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [5:0] exp_op;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n0, p1, e0, exp_err, stable_bad;
    logic [7:0] exp_q[$];
    logic [7:0] r, a, b, c;

    vecs[0] = '{a: 8'h05, b: 8'h03, c: 8'h20, exp_op: 6'h20};
    vecs[1] = '{a: 8'h0A, b: 8'hF0, c: 8'hE1, exp_op: 6'h21};
    vecs[2] = '{a: 8'hFF, b: 8'h01, c: 8'h3F, exp_op: 6'h3F};
    vecs[3] = '{a: 8'h00, b: 8'h00, c: 8'hC0, exp_op: 6'h00};

    // Reset state
    tick(3);
    check("reset op_a", o_op_a, 0);
    check("reset op_b", o_op_b, 0);
    check("reset op_code", o_op_code, 0);
    check("reset busy", o_busy, 0);
    check("reset wr", o_wr, 0);
    check("reset rd", o_rd, 0);
    check("reset frame_err", o_frame_err, 0);
    check("reset tx_data", o_tx_data, 0);
    i_reset = 1'b0;
    tick(2);

    // Vector table: operand capture, opcode masking, latency and push order
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      push3(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_pushes($sformatf("vec%0d", i), 2, 200);
      n0 = pop_edges[0];
      tick(1);
      check($sformatf("vec%0d op_a", i), o_op_a, vecs[i].a);
      check($sformatf("vec%0d op_b", i), o_op_b, vecs[i].b);
      check($sformatf("vec%0d op_code", i), o_op_code, vecs[i].exp_op);
      check($sformatf("vec%0d pop gap", i), pop_edges[2] - n0, 2);
      check($sformatf("vec%0d res", i), tx_data_log[0],
            alu_res(vecs[i].a, vecs[i].b, vecs[i].exp_op));
      check($sformatf("vec%0d flags", i), tx_data_log[1],
            {3'b000, alu_flg(vecs[i].a, vecs[i].b, vecs[i].exp_op)});
      check($sformatf("vec%0d res edge", i), tx_edge_log[0], n0 + 3 + Lat);
      check($sformatf("vec%0d flg edge", i), tx_edge_log[1], n0 + 4 + Lat);
      check($sformatf("vec%0d busy", i), o_busy, 0);
      check($sformatf("vec%0d idle tx_data", i), o_tx_data, 0);
    end

    // Back-to-back frames: next pop on the edge after the flags push
    clear_logs();
    push3(8'h12, 8'h34, 8'h07);
    push3(8'h56, 8'h78, 8'h09);
    wait_pushes("b2b", 4, 300);
    check("b2b next pop edge", pop_edges[3], tx_edge_log[1] + 1);
    check("b2b res2", tx_data_log[2], alu_res(8'h56, 8'h78, 6'h09));
    check("b2b flg2", tx_data_log[3], {3'b000, alu_flg(8'h56, 8'h78, 6'h09)});

    // Timeout discard after two bytes
    clear_logs();
    e0 = err_cnt;
    rx_q.push_back(8'h0A);
    rx_q.push_back(8'h0B);
    wait_pops("timeout", 2);
    p1 = pop_edges[1];
    tick(To + 3);
    check("timeout err pulses", err_cnt - e0, 1);
    check("timeout err edge", err_edge, p1 + To + 1);
    check("timeout no push", tx_data_log.size(), 0);
    check("timeout busy", o_busy, 0);
    check("timeout op_a kept", o_op_a, 8'h0A);
    check("timeout op_b kept", o_op_b, 8'h0B);
    push3(8'h11, 8'h22, 8'h05);
    wait_pushes("after timeout", 2, 200);
    check("after timeout op_a", o_op_a, 8'h11);
    check("after timeout res", tx_data_log[0], alu_res(8'h11, 8'h22, 6'h05));

    // Byte lands on the terminal empty cycle: pop wins, no error
    clear_logs();
    e0 = err_cnt;
    rx_q.push_back(8'h0A);
    rx_q.push_back(8'h0B);
    wait_pops("terminal", 2);
    p1 = pop_edges[1];
    while (cyc < p1 + To) tick(1);
    rx_q.push_back(8'h33);
    wait_pushes("terminal", 2, 200);
    check("terminal pop edge", pop_edges[2], p1 + To);
    check("terminal no err", err_cnt - e0, 0);
    check("terminal res", tx_data_log[0], alu_res(8'h0A, 8'h0B, 6'h33));
    check("terminal flg", tx_data_log[1], {3'b000, alu_flg(8'h0A, 8'h0B, 6'h33)});

    // TX backpressure raised in SEND_RES
    clear_logs();
    push3(8'hA5, 8'h5A, 8'h2C);
    r = alu_res(8'hA5, 8'h5A, 6'h2C);
    wait_pops("txfull", 1);
    n0 = pop_edges[0];
    while (cyc < n0 + 3 + Lat) tick(1);
    check("txfull wr before stall", o_wr, 1);
    full_req = 1'b1;
    #1;
    check("txfull wr drops", o_wr, 0);
    check("txfull tx_data", o_tx_data, r);
    stable_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (o_tx_data !== r || o_wr !== 1'b0) stable_bad++;
    end
    check("txfull stable 50 cycles", stable_bad, 0);
    check("txfull no push", tx_data_log.size(), 0);
    full_req = 1'b0;
    wait_pushes("txfull release", 2, 50);
    tick(5);
    check("txfull exactly two", tx_data_log.size(), 2);
    check("txfull res first", tx_data_log[0], r);
    check("txfull flg second", tx_data_log[1], {3'b000, alu_flg(8'hA5, 8'h5A, 6'h2C)});

    // Reset while in GET_OP
    clear_logs();
    e0 = err_cnt;
    rx_q.push_back(8'h44);
    rx_q.push_back(8'h55);
    wait_pops("rst getop", 2);
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    check("rst getop op_a", o_op_a, 0);
    check("rst getop op_b", o_op_b, 0);
    check("rst getop busy", o_busy, 0);
    tick(To + 5);
    check("rst getop no err", err_cnt - e0, 0);
    check("rst getop no push", tx_data_log.size(), 0);
    push3(8'h66, 8'h77, 8'h08);
    wait_pushes("rst getop next", 2, 200);
    check("rst getop next res", tx_data_log[0], alu_res(8'h66, 8'h77, 6'h08));

    // Reset while in SEND_FLG
    clear_logs();
    push3(8'h99, 8'h88, 8'h3A);
    wait_pushes("rst sendflg", 1, 200);
    full_req = 1'b1;
    i_reset  = 1'b1;
    tick(1);
    i_reset  = 1'b0;
    full_req = 1'b0;
    check("rst sendflg op_a", o_op_a, 0);
    check("rst sendflg op_code", o_op_code, 0);
    check("rst sendflg busy", o_busy, 0);
    tick(10);
    check("rst sendflg no flags push", tx_data_log.size(), 1);
    push3(8'h01, 8'h02, 8'h03);
    wait_pushes("rst sendflg next", 3, 200);
    check("rst sendflg next res", tx_data_log[1], alu_res(8'h01, 8'h02, 6'h03));
    check("rst sendflg next flg", tx_data_log[2], {3'b000, alu_flg(8'h01, 8'h02, 6'h03)});

    // Randomized frames, random TX backpressure, occasional abandoned frames
    clear_logs();
    rand_full = 1'b1;
    e0 = err_cnt;
    exp_err = 0;
    for (int f = 0; f < 30; f++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      tick($urandom_range(0, To / 2));
      rx_q.push_back(a);
      tick($urandom_range(0, To / 2));
      rx_q.push_back(b);
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < 3000 && rx_q.size() != 0; k++) tick(1);
        tick(To + 4);
        exp_err++;
      end else begin
        tick($urandom_range(0, To / 2));
        rx_q.push_back(c);
        exp_q.push_back(alu_res(a, b, c[5:0]));
        exp_q.push_back({3'b000, alu_flg(a, b, c[5:0])});
      end
    end
    wait_pushes("random", exp_q.size(), 5000);
    for (int i = 0; i < exp_q.size() && i < tx_data_log.size(); i++)
      check($sformatf("random byte %0d", i), tx_data_log[i], exp_q[i]);
    check("random err count", err_cnt - e0, exp_err);
    rand_full = 1'b0;

    check("rd/wr never together", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
